// File: rtl/mem_pkg.sv
// Shared types for the data-RAM controller: access sizes, FSM states,
// the data width and the lane-mask helper.
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       we;
    logic       err;
    logic       sgn;
    logic [1:0] size;
    logic [1:0] off;
  } rsp_ctl_t;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (size)
      SIZE_B:  m = 4'b0001 << off;
      SIZE_H:  m = 4'b0011 << off;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus of the data-RAM controller.
// master = MEM stage side, slave = controller side.
interface data_ram_ctrl_if #(
  parameter int ADDR_W = 32
);
  import mem_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_size_i;
  logic              req_signed_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              init_done_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i,
    output req_size_i, req_signed_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o, init_done_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i,
    input  req_size_i, req_signed_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output rsp_err_o, init_done_o
  );

endinterface

// File: rtl/byte_bank.sv
// One byte lane of data storage: DEPTH x 8 synchronous RAM.
// Ports: clk, we/addr/wdata write, re + registered rdata read.
module byte_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Load/store data-memory controller: clear-after-reset, valid/ready bus,
// lane steering, load extension and misaligned/range error reporting.
// Ports: clk, rst_n (async, active-low), bus (data_ram_ctrl_if.slave).
module data_ram_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 10,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  data_ram_ctrl_if.slave  bus
);

  localparam logic [DEPTH_LOG2-1:0] LAST = '1;

  state_e   state, state_nx;
  rsp_ctl_t ctl, ctl_nx;

  logic [DEPTH_LOG2-1:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] bank_addr;
  logic [1:0]            off;
  logic [3:0]            be;
  logic [3:0]            bank_we;
  logic                  bank_re;
  logic [DATA_W-1:0]     wd_rep;
  logic [DATA_W-1:0]     bank_wd;
  logic [DATA_W-1:0]     rd;
  logic [DATA_W-1:0]     sh;
  logic [DATA_W-1:0]     ext;
  logic                  mis;
  logic                  hi_err;
  logic                  err;
  logic                  ready;
  logic                  accept;
  logic                  init_wr;

  assign idx = bus.req_addr_i[DEPTH_LOG2+1:2];
  assign off = bus.req_addr_i[1:0];

  if (ADDR_W > DEPTH_LOG2 + 2) begin : g_hi
    assign hi_err = |bus.req_addr_i[ADDR_W-1:DEPTH_LOG2+2];
  end else begin : g_nohi
    assign hi_err = 1'b0;
  end

  always_comb begin
    mis    = 1'b0;
    wd_rep = bus.req_wdata_i;
    unique case (size_e'(bus.req_size_i))
      SIZE_B: wd_rep = {4{bus.req_wdata_i[7:0]}};
      SIZE_H: begin
        mis    = off[0];
        wd_rep = {2{bus.req_wdata_i[15:0]}};
      end
      SIZE_W:  mis = |off;
      default: mis = 1'b1;
    endcase
  end

  assign err    = mis | hi_err;
  assign be     = lane_mask(bus.req_size_i, off);
  assign ready  = (state == IDLE) ||
                  (state == RESP && bus.rsp_ready_i);
  assign accept = bus.req_valid_i && ready;

  assign init_wr = (state == INIT) && (CLEAR_ON_RESET != 0);

  // Clearing owns the banks while in INIT; no request can be
  // accepted then, so the two users never collide.
  always_comb begin
    bank_addr = idx;
    bank_wd   = wd_rep;
    bank_we   = 4'b0000;
    bank_re   = accept && !bus.req_we_i && !err;
    if (init_wr) begin
      bank_addr = cnt;
      bank_wd   = '0;
      bank_we   = 4'b1111;
    end else if (accept && bus.req_we_i && !err) begin
      bank_we   = be;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    byte_bank #(
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[k]),
      .re    (bank_re),
      .addr  (bank_addr),
      .wdata (bank_wd[8*k +: 8]),
      .rdata (rd[8*k +: 8])
    );
  end

  always_comb begin
    ctl_nx      = ctl;
    ctl_nx.we   = bus.req_we_i;
    ctl_nx.err  = err;
    ctl_nx.sgn  = bus.req_signed_i;
    ctl_nx.size = bus.req_size_i;
    ctl_nx.off  = off;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: begin
        if (CLEAR_ON_RESET == 0 || cnt == LAST)
          state_nx = IDLE;
      end
      IDLE: begin
        if (accept) state_nx = RESP;
      end
      RESP: begin
        if (accept)                state_nx = RESP;
        else if (bus.rsp_ready_i)  state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ctl   <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (accept)        ctl <= ctl_nx;
    end
  end

  // The bank read registers are not reset; the response path is
  // gated by state so outputs drop to zero with reset.
  assign sh = rd >> {ctl.off, 3'b000};

  always_comb begin
    ext = rd;
    unique case (size_e'(ctl.size))
      SIZE_B:  ext = {{24{ctl.sgn & sh[7]}}, sh[7:0]};
      SIZE_H:  ext = {{16{ctl.sgn & sh[15]}}, sh[15:0]};
      default: ext = rd;
    endcase
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_err_o   = (state == RESP) && ctl.err;
  assign bus.rsp_rdata_o =
    (state == RESP && !ctl.we && !ctl.err) ? ext : '0;
  assign bus.init_done_o = (state != INIT);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl (DEPTH_LOG2=4).
// Scoreboard: expected {err,rdata} queued on accept, compared on response.
module tb_data_ram_ctrl;

  localparam int DL = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [32:0] exp_q [$];
  logic [32:0] obs_q [$];
  int          obs_t [$];

  always #5 clk = ~clk;

  data_ram_ctrl_if #(.ADDR_W(AW)) bus();

  data_ram_ctrl #(
    .DEPTH_LOG2     (DL),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: samples one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      obs_q.push_back({bus.rsp_err_o, bus.rsp_rdata_o});
      obs_t.push_back(cyc);
    end
  end

  task automatic send(
    input logic        we,
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [31:0] wd,
    input logic [32:0] exp
  );
    bit ok;
    ok = 0;
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_addr_i   = addr;
    bus.req_size_i   = size;
    bus.req_signed_i = sgn;
    bus.req_wdata_i  = wd;
    for (int i = 0; i < 50; i++) begin
      #4;
      if (bus.req_ready_o) ok = 1;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (ok) begin
      exp_q.push_back(exp);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept addr=%h ready=0 required=1", addr);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50; i++) begin
      if (obs_q.size() >= exp_q.size()) break;
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic release_rst(output int n, output bit bad);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    bad = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done_o) break;
      if (bus.req_ready_o) bad = 1;
    end
  endtask

  task automatic test_reset();
    int n;
    bit bad;
    logic [32:0] e, o;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o,
         bus.rsp_err_o, bus.init_done_o} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b req=0",
        {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
         bus.init_done_o});
    end
    release_rst(n, bad);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL init_cycles got=%0d req=16", n);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL init_ready got=1 req=0");
    end
    send(1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, {1'b0, 32'h0});
    idle();
    wait_rsp();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_rsp_count got=%0d req=%0d",
        obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_t.pop_front());
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_load got=%h req=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_store_load();
    logic [32:0] e, o;
    send(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 33'h0);
    send(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, {1'b0, 32'hFFFFFFBE});
    send(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, {1'b0, 32'h000000BE});
    send(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, {1'b0, 32'hFFFFDEAD});
    send(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, {1'b0, 32'h0000BEEF});
    send(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, {1'b0, 32'hFFFFFFDE});
    send(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000055, 33'h0);
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, {1'b0, 32'h55ADBEEF});
    idle();
    wait_rsp();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL sl_rsp_count got=%0d req=%0d",
        obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_t.pop_front());
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL store_load got=%h req=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_errors();
    logic [32:0] e, o;
    send(1'b0, 32'h11, 2'b01, 1'b1, 32'h0, {1'b1, 32'h0});
    send(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, {1'b1, 32'h0});
    send(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, {1'b1, 32'h0});
    send(1'b1, 32'h40, 2'b10, 1'b0, 32'h12345678, {1'b1, 32'h0});
    send(1'b1, 32'h13, 2'b01, 1'b0, 32'h0000FFFF, {1'b1, 32'h0});
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, {1'b0, 32'h55ADBEEF});
    send(1'b0, 32'h00, 2'b10, 1'b0, 32'h0, {1'b0, 32'h0});
    idle();
    wait_rsp();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL err_rsp_count got=%0d req=%0d",
        obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_t.pop_front());
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL error_access got=%h req=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_back_to_back();
    logic [32:0] e, o;
    int t_prev, t_cur;
    send(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 33'h0);
    send(1'b1, 32'h24, 2'b10, 1'b0, 32'hA5A55A5A, 33'h0);
    idle();
    wait_rsp();
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, {1'b0, 32'h55ADBEEF});
    @(negedge clk);
    bus.rsp_ready_i  = 1'b0;
    bus.req_addr_i   = 32'h20;
    bus.req_size_i   = 2'b10;
    bus.req_we_i     = 1'b0;
    bus.req_signed_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      checks++;
      if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o,
           bus.req_ready_o} !== {2'b10, 32'h55ADBEEF, 1'b0}) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%b_%b_%h_%b", i,
          bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o,
          bus.req_ready_o);
      end
      @(posedge clk);
    end
    #1;
    bus.rsp_ready_i = 1'b1;
    send(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, {1'b0, 32'h11223344});
    send(1'b0, 32'h24, 2'b10, 1'b0, 32'h0, {1'b0, 32'hA5A55A5A});
    send(1'b0, 32'h26, 2'b01, 1'b0, 32'h0, {1'b0, 32'h0000A5A5});
    send(1'b0, 32'h26, 2'b00, 1'b1, 32'h0, {1'b0, 32'hFFFFFFA5});
    idle();
    wait_rsp();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_rsp_count got=%0d req=%0d",
        obs_q.size(), exp_q.size());
    end
    t_prev = -1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      t_cur = obs_t.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_data got=%h req=%h", o, e);
      end
      if (t_prev >= 0) begin
        checks++;
        if (t_cur - t_prev !== 1) begin
          failures++;
          $display("FAIL b2b_gap got=%0d req=1", t_cur - t_prev);
        end
      end
      t_prev = t_cur;
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    logic [32:0] e, o;
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, {1'b0, 32'h55ADBEEF});
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o,
         bus.rsp_err_o, bus.init_done_o} !== 36'd0) begin
      failures++;
      $display("FAIL rst_in_resp got=%b_%b_%h_%b_%b",
        bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o,
        bus.rsp_err_o, bus.init_done_o);
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    bus.rsp_ready_i = 1'b1;
    release_rst(n, bad);
    checks++;
    if (n !== 16 || bad) begin
      failures++;
      $display("FAIL rerun_init1 got=%0d bad=%0d req=16", n, bad);
    end
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, {1'b0, 32'h0});
    idle();
    wait_rsp();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_t.pop_front());
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL recleared got=%h req=%h", o, e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL recleared_rsp missing=%0d req=0", exp_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o,
         bus.rsp_err_o, bus.init_done_o} !== 36'd0) begin
      failures++;
      $display("FAIL rst_in_init got=%b_%b_%b",
        bus.req_ready_o, bus.rsp_valid_o, bus.init_done_o);
    end
    release_rst(n, bad);
    checks++;
    if (n !== 16 || bad) begin
      failures++;
      $display("FAIL rerun_init2 got=%0d bad=%0d req=16", n, bad);
    end
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_size_i   = 2'b00;
    bus.req_signed_i = 1'b0;
    bus.req_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b1;
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Parametrised data-memory controller for the load/store path, sitting between the MEM stage and byte-lane data storage. It generalises the fixed 4-bank data RAM in four ways: configurable depth, a valid/ready request and response handshake, internal byte-enable generation with sub-word load extension, and error reporting for misaligned or out-of-range accesses. It also clears all storage after reset and keeps responses in order.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: memory depth in 32-bit words (2^DEPTH_LOG2).
- `ADDR_W`, 32: byte-address width; must be ≥ DEPTH_LOG2+2.
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset before accepting requests.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted this cycle when high with `req_valid_i`.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  ADDR_W  byte address.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed_i`  in  1  load sign-extends when 1, zero-extends when 0.
- `req_wdata_i`  in  32  store data, right-aligned; the block shifts it to the lane.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `rsp_err_o`  out  1  misaligned, reserved size or out-of-range.
- `init_done_o`  out  1  high once the clear sequence has finished.

## Operation
- Memory is little-endian: lane k holds bits 8k+7:8k. The word index is `addr[DEPTH_LOG2+1:2]`.
- FSM states:
  - INIT: with CLEAR_ON_RESET=1, writes zero to word counter 0..DEPTH-1, one word per cycle, then moves to IDLE.
  - IDLE: waits for a request.
  - RESP: holds the pending response.
- With CLEAR_ON_RESET=0, the block leaves INIT on the first clock after reset release.
- `req_ready_o = (state==IDLE) || (state==RESP && rsp_ready_i)`. It is combinational on `rsp_ready_i`, which allows one request per cycle.
- On accept:
  - A store writes the enabled lanes at that edge.
  - A load reads the addressed word at that edge.
  - The FSM moves to RESP; it stays in RESP on back-to-back accepts.
- Byte enables:
  - byte = `4'b0001 << addr[1:0]`
  - half = `4'b0011 << addr[1:0]`
  - word = `4'b1111`
- Store data is replicated across lanes before masking.
- Loads extract the addressed lane(s), then sign- or zero-extend to 32 bits.
- Error cases (`rsp_err_o`=1):
  - half with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - size 11
  - any `addr[ADDR_W-1:DEPTH_LOG2+2]` nonzero
- An errored access never modifies memory, returns rdata 0 and still produces exactly one response.
- In RESP with `rsp_ready_i`=0, all `rsp_*` outputs hold stable and `req_ready_o`=0.
- In RESP with `rsp_ready_i`=1 and no new request, the FSM returns to IDLE.

## Timing
- Reset values:
  - `req_ready_o` 0, `rsp_valid_o` 0, `rsp_rdata_o` 0, `rsp_err_o` 0, `init_done_o` 0.
  - FSM goes to INIT and the clear counter to 0.
- Load latency: accept at edge T, response valid from T until consumed.
- A store followed by a load to the same word on the next accept returns the new data; the write lands at the earlier edge.
- Clear sequence: `init_done_o` rises exactly 2^DEPTH_LOG2 cycles after the first post-reset edge; `req_ready_o` is 0 throughout.
- Reset asserted mid-INIT: the counter restarts from 0 after release.
- Reset asserted in RESP: the response is dropped and `rsp_valid_o` falls asynchronously. Memory contents are then undefined until re-cleared.

## Structure
- Shared package `mem_pkg`:
  - size encodings (SIZE_B/H/W/RSV)
  - FSM state enum (INIT/IDLE/RESP)
  - the 32-bit data width constant
- Sub-module `byte_bank`: a DEPTH×8 synchronous RAM with one write enable and a registered read. It is instantiated four times, one per lane.
- Lane steering, extension and error detection stay in the top level.

## Test plan
- Reset, DEPTH_LOG2=4, CLEAR_ON_RESET=1 -> `init_done_o` rises after 16 cycles; load word 0x3C returns 0x00000000, err 0.
- Store word 0x10 = 0xDEADBEEF, then the following loads:
  - signed byte 0x11 -> 0xFFFFFFBE
  - unsigned byte 0x11 -> 0x000000BE
  - signed half 0x12 -> 0xFFFFDEAD
- Store byte 0x55 at 0x13 over 0xDEADBEEF -> load word 0x10 returns 0x55ADBEEF.
- Error accesses (DEPTH_LOG2=4) -> each returns err 1 and rdata 0; a subsequent word load 0x10 is unchanged:
  - half 0x11
  - word 0x12
  - size 11
  - store word 0x40
- Hold `rsp_ready_i` low 3 cycles -> response stable and `req_ready_o` 0. Release with 4 queued loads -> 4 in-order responses on 4 consecutive cycles.
- Assert `rst_n` during RESP, and separately at clear count 7 -> all outputs 0 immediately; INIT reruns the full 16 cycles.
